// File: rtl/vc_trace_line_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | vc_trace_line_sched_pkg: states, ASCII constants and char helpers           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package vc_trace_line_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CYC   = 3'd1,
        ST_COLON = 3'd2,
        ST_SPACE = 3'd3,
        ST_LOAD  = 3'd4,
        ST_FIELD = 3'd5,
        ST_SEP   = 3'd6,
        ST_NL    = 3'd7
    } state_t;

    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_BAR   = 8'h7C;
    localparam logic [7:0] CH_NL    = 8'h0A;

    // Lowercase hex: 'a' - 10 = 8'h57
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] digit_char(input logic [31:0] value, input int pos);
        logic [31:0] shifted;
        shifted    = value >> (4 * pos);
        digit_char = hex_char(shifted[3:0]);
    endfunction

    function automatic logic [7:0] nul_to_space(input logic [7:0] c);
        nul_to_space = (c == CH_NUL) ? CH_SPACE : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vc_trace_line_sched_shreg.sv
// +----------------------------------------------------------------------------+
// | vc_trace_line_sched_shreg: field load/shift register, MSB byte first        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_trace_line_sched_shreg
    import vc_trace_line_sched_pkg::*;
#(
    parameter int FIELD_CHARS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     shift,
    input  logic [FIELD_CHARS*8-1:0] load_data,
    output logic [7:0]               load_char,
    output logic [7:0]               head_char,
    output logic                     last
);

    localparam int W  = FIELD_CHARS * 8;
    localparam int IW = (FIELD_CHARS > 1) ? $clog2(FIELD_CHARS) : 1;

    logic [W-1:0]  data;
    logic [IW-1:0] idx;

    // The first char is presented straight from load_data, so the register
    // only keeps the remaining chars and idx tracks the char on the output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
            idx  <= '0;
        end else if (load) begin
            data <= load_data << 8;
            idx  <= '0;
        end else if (shift) begin
            data <= data << 8;
            idx  <= idx + 1'b1;
        end
    end

    assign load_char = nul_to_space(load_data[W-1 -: 8]);
    assign head_char = nul_to_space(data[W-1 -: 8]);
    assign last      = (idx == IW'(FIELD_CHARS - 1));

endmodule

`default_nettype wire

// File: rtl/vc_trace_line_sched.sv
// +----------------------------------------------------------------------------+
// | vc_trace_line_sched: serializes one text trace line per accepted tick       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_trace_line_sched
    import vc_trace_line_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int FIELD_CHARS = 8,
    parameter int CYC_DIGITS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NREQ-1:0]               req_val,
    input  logic [NREQ*FIELD_CHARS*8-1:0] req_data,
    output logic [NREQ-1:0]               req_rdy,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [7:0]                    out_char,
    output logic                          busy,
    output logic [31:0]                   cycles,
    output logic                          overrun
);

    localparam int FW = FIELD_CHARS * 8;
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (CYC_DIGITS > 1) ? $clog2(CYC_DIGITS) : 1;

    state_t        state;
    logic [SW-1:0] slot;
    logic [DW-1:0] digit;
    logic [31:0]   cyc_snap;

    logic [FW-1:0] slice;
    logic [FW-1:0] load_data;
    logic [7:0]    load_char;
    logic [7:0]    head_char;
    logic          field_last;
    logic          fire;

    assign slice     = req_data[slot*FW +: FW];
    assign load_data = req_val[slot] ? slice : {FIELD_CHARS{CH_SPACE}};
    assign fire      = out_val && out_rdy;
    assign busy      = (state != ST_IDLE);

    vc_trace_line_sched_shreg #(
        .FIELD_CHARS (FIELD_CHARS)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load      (state == ST_LOAD),
        .shift     ((state == ST_FIELD) && fire && !field_last),
        .load_data (load_data),
        .load_char (load_char),
        .head_char (head_char),
        .last      (field_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            slot     <= '0;
            digit    <= '0;
            cyc_snap <= '0;
            req_rdy  <= '0;
            out_val  <= 1'b0;
            out_char <= '0;
            cycles   <= '0;
            overrun  <= 1'b0;
        end else begin
            // Every tick is counted, even the ones that cannot start a line
            if (tick) begin
                cycles <= cycles + 32'd1;
                if (state != ST_IDLE) begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state    <= ST_CYC;
                        digit    <= '0;
                        cyc_snap <= cycles;
                        out_val  <= 1'b1;
                        out_char <= digit_char(cycles, CYC_DIGITS - 1);
                    end
                end
                ST_CYC: begin
                    if (fire) begin
                        if (digit == DW'(CYC_DIGITS - 1)) begin
                            state    <= ST_COLON;
                            out_char <= CH_COLON;
                        end else begin
                            digit    <= digit + 1'b1;
                            out_char <= digit_char(cyc_snap, CYC_DIGITS - 2 - int'(digit));
                        end
                    end
                end
                ST_COLON: begin
                    if (fire) begin
                        state    <= ST_SPACE;
                        out_char <= CH_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (fire) begin
                        state   <= ST_LOAD;
                        slot    <= '0;
                        out_val <= 1'b0;
                        req_rdy <= NREQ'(1);
                    end
                end
                ST_LOAD: begin
                    state    <= ST_FIELD;
                    req_rdy  <= '0;
                    out_val  <= 1'b1;
                    out_char <= load_char;
                end
                ST_FIELD: begin
                    if (fire) begin
                        if (!field_last) begin
                            out_char <= head_char;
                        end else if (slot == SW'(NREQ - 1)) begin
                            state    <= ST_NL;
                            out_char <= CH_NL;
                        end else begin
                            state    <= ST_SEP;
                            out_char <= CH_BAR;
                        end
                    end
                end
                ST_SEP: begin
                    if (fire) begin
                        state   <= ST_LOAD;
                        slot    <= slot + 1'b1;
                        out_val <= 1'b0;
                        req_rdy <= NREQ'(1) << (slot + 1'b1);
                    end
                end
                ST_NL: begin
                    if (fire) begin
                        state   <= ST_IDLE;
                        out_val <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    out_val <= 1'b0;
                    req_rdy <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vc_trace_line_sched.sv
// +----------------------------------------------------------------------------+
// | tb_vc_trace_line_sched: vector table, random traffic and reset corners      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vc_trace_line_sched;

    localparam int NREQ = 4;
    localparam int FC   = 8;
    localparam int CD   = 4;
    localparam int LW   = 42 * 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [NREQ-1:0]  req_val;
    logic [255:0]     req_data;
    logic [NREQ-1:0]  req_rdy;
    logic             out_val;
    logic             out_rdy;
    logic [7:0]       out_char;
    logic             busy;
    logic [31:0]      cycles;
    logic             overrun;

    always #5 clk = ~clk;

    vc_trace_line_sched #(
        .NREQ        (NREQ),
        .FIELD_CHARS (FC),
        .CYC_DIGITS  (CD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req_val  (req_val),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_char (out_char),
        .busy     (busy),
        .cycles   (cycles),
        .overrun  (overrun)
    );

    typedef struct packed {
        logic [3:0]    val;
        logic [255:0]  data;
        logic [7:0]    stall;
        logic [LW-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    int ncmp  = 0;
    int nfail = 0;

    // Reference model state
    int unsigned   mcycles;
    bit            mbusy;
    bit            moverrun;
    logic [LW-1:0] exp_q [$];
    logic [LW-1:0] rx;
    logic [LW-1:0] last_line;
    int            rxn;
    int            lines_done;
    int            lcnt;
    bit            allrdy;
    bit            prev_stall;
    bit            just_acc;
    logic [7:0]    prev_char;
    int            slots_seen;

    function automatic logic [LW-1:0] build_line(input int unsigned cyc, input logic [3:0] v,
                                                 input logic [255:0] d);
        logic [LW-1:0] r;
        logic [7:0]    c;
        int unsigned   nib;
        r = '0;
        for (int k = 0; k < CD; k++) begin
            nib = (cyc >> (4 * (CD - 1 - k))) & 32'hF;
            c   = (nib < 10) ? 8'(48 + nib) : 8'(87 + nib);
            r   = {r[LW-9:0], c};
        end
        r = {r[LW-9:0], 8'h3A};
        r = {r[LW-9:0], 8'h20};
        for (int i = 0; i < NREQ; i++) begin
            if (i > 0) r = {r[LW-9:0], 8'h7C};
            for (int k = 0; k < FC; k++) begin
                c = d[i*64 + (7-k)*8 +: 8];
                if (!v[i] || c == 8'h00) c = 8'h20;
                r = {r[LW-9:0], c};
            end
        end
        r = {r[LW-9:0], 8'h0A};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mcycles    = 0;
        mbusy      = 1'b0;
        moverrun   = 1'b0;
        exp_q.delete();
        rx         = '0;
        rxn        = 0;
        lcnt       = 0;
        allrdy     = 1'b0;
        prev_stall = 1'b0;
        just_acc   = 1'b0;
        slots_seen = 0;
    endtask

    // One clock: called at a falling edge, returns at the next falling edge
    task automatic step(input bit tk, input bit rdy);
        bit         xfer;
        logic [7:0] ch;
        tick    = tk;
        out_rdy = rdy;

        chk("busy", 64'(busy), 64'(mbusy));
        chk("cycles", 64'(cycles), 64'(mcycles));
        chk("overrun", 64'(overrun), 64'(moverrun));
        if (!mbusy) chk("idle_out_val", 64'(out_val), 64'd0);
        if (prev_stall) begin
            chk("stall_val", 64'(out_val), 64'd1);
            chk("stall_char", 64'(out_char), 64'(prev_char));
        end
        if (just_acc) chk("first_digit_latency", 64'(out_val), 64'd1);
        if (req_rdy != '0) begin
            chk("req_rdy_slot", 64'(req_rdy), 64'(1) << slots_seen);
            chk("load_out_val", 64'(out_val), 64'd0);
            slots_seen++;
        end

        xfer     = out_val && rdy;
        ch       = out_char;
        just_acc = 1'b0;
        if (mbusy) begin
            lcnt++;
            allrdy &= rdy;
        end
        if (tk) begin
            if (mbusy) begin
                moverrun = 1'b1;
            end else begin
                exp_q.push_back(build_line(mcycles, req_val, req_data));
                mbusy      = 1'b1;
                just_acc   = 1'b1;
                lcnt       = 0;
                allrdy     = 1'b1;
                slots_seen = 0;
                rx         = '0;
                rxn        = 0;
            end
            mcycles++;
        end
        if (xfer && !just_acc) begin
            rx = {rx[LW-9:0], ch};
            rxn++;
            if (ch == 8'h0A) begin
                chk("line_len", 64'(rxn), 64'd42);
                chk("line_slots", 64'(slots_seen), 64'(NREQ));
                if (allrdy) chk("line_cycles", 64'(lcnt), 64'd46);
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_line: got %h required none", rx);
                end else begin
                    chk_line("line", rx, exp_q.pop_front());
                end
                last_line = rx;
                rx        = '0;
                rxn       = 0;
                mbusy     = 1'b0;
                lines_done++;
            end
        end
        prev_stall = out_val && !rdy;
        prev_char  = out_char;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_line(input int stall);
        int start;
        start = lines_done;
        for (int n = 0; n < 800 && lines_done == start; n++) begin
            step(1'b0, ($urandom_range(0, 99) >= stall));
        end
        chk("line_timeout", 64'(lines_done - start), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 800 && mbusy; n++) step(1'b0, 1'b1);
        chk("drain_timeout", 64'(mbusy), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick  = 1'b0;
        #1;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_char", 64'(out_char), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'hF, {"DDDDDDDD", "CCCCCCCC", "BBBBBBBB", "AAAAAAAA"}, 8'd0,
                    "0000: AAAAAAAA|BBBBBBBB|CCCCCCCC|DDDDDDDD\n"};
        vecs[1] = '{4'b0101, {"dddddddd", "Hello123", "zzzzzzzz", {"ab", 48'h0}}, 8'd0,
                    "0001: ab      |        |Hello123|        \n"};
        vecs[2] = '{4'b1010, {"WXYZwxyz", "11111111", {"q", 8'h00, "r", 40'h0}, "22222222"}, 8'd30,
                    "0002:         |q r     |        |WXYZwxyz\n"};
        vecs[3] = '{4'hF, {"DDDDDDDD", "CCCCCCCC", "BBBBBBBB", "AAAAAAAA"}, 8'd30,
                    "0003: AAAAAAAA|BBBBBBBB|CCCCCCCC|DDDDDDDD\n"};

        reset      = 1'b0;
        tick       = 1'b0;
        out_rdy    = 1'b0;
        req_val    = '0;
        req_data   = '0;
        lines_done = 0;
        last_line  = '0;
        prev_char  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Table vectors: one line each, cycles prefix equals vector index
        for (int i = 0; i < 4; i++) begin
            req_val  = vecs[i].val;
            req_data = vecs[i].data;
            step(1'b1, 1'b1);
            wait_line(int'(vecs[i].stall));
            chk_line("vec_line", last_line, vecs[i].exp);
        end

        // Random traffic: sporadic ticks, 30% sink stalls, NUL-laden fields
        for (int n = 0; n < 1500; n++) begin
            if (!mbusy && $urandom_range(0, 3) == 0) begin
                req_val = 4'($urandom_range(0, 15));
                for (int b = 0; b < 32; b++) begin
                    req_data[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00
                                         : 8'($urandom_range(32, 126));
                end
            end
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 99) >= 30));
        end
        drain();

        // Tick every cycle: drops counted, overrun set by the second tick
        do_reset();
        req_val  = 4'hF;
        req_data = {"DDDDDDDD", "CCCCCCCC", "BBBBBBBB", "AAAAAAAA"};
        for (int n = 0; n < 150; n++) step(1'b1, 1'b1);
        chk("overrun_sticky", 64'(overrun), 64'd1);
        drain();

        // Reset at char 10 of a line aborts it at once
        do_reset();
        step(1'b1, 1'b1);
        for (int n = 0; n < 100 && rxn < 10; n++) step(1'b0, 1'b1);
        chk("abort_point", 64'(rxn), 64'd10);
        do_reset();
        step(1'b1, 1'b1);
        wait_line(0);
        chk("abort_fresh_prefix", 64'(last_line[LW-1 -: 48]), 64'("0000: "));

        // Preset the counter to 0x1234 with back-to-back ticks
        do_reset();
        for (int n = 0; n < 32'h1234; n++) step(1'b1, 1'b1);
        drain();
        chk("preset_cycles", 64'(cycles), 64'h1234);
        step(1'b1, 1'b1);
        wait_line(0);
        chk("preset_prefix", 64'(last_line[LW-1 -: 48]), 64'("1234: "));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
